// File: rtl/sensor_sampler.sv
`default_nettype none
// ============================================================================
// Module      : sensor_sampler
// Description : Synchronises an asynchronous sensor bus, samples it every DIV
//               clocks, averages 2^LOG2_AVG samples per output word and hands
//               the word downstream over a valid/ready handshake.
//               Optional build macro SENSOR_SAMPLER_OVERRUN_CNT_EN adds a
//               saturating 16-bit overrun counter port (overrun_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_sampler #(
  parameter int DATA_W      = 8,
  parameter int DIV         = 4,
  parameter int LOG2_AVG    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] sensor_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
`ifdef SENSOR_SAMPLER_OVERRUN_CNT_EN
  output logic [15:0]       overrun_cnt,
`endif
  output logic              busy
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q, sync_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  logic [DATA_W-1:0] synced;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] result;
  logic              tick;
  logic              last;
  logic              result_valid;
  logic              load;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift the raw bus through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sensor_in};
  end

  // Divider, sample counter and accumulator; result forms on the final tick.
  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    tick         = en && (div_q == DIV_LAST);
    last         = (cnt_q == CNT_LAST);
    sum          = acc_q + ACC_W'(synced);
    result       = sum[ACC_W-1:LOG2_AVG];
    result_valid = tick && last;
    if (!en) begin
      div_d = '0;
      cnt_d = '0;
      acc_d = '0;
    end else if (tick) begin
      div_d = '0;
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Output register: a fresh result loads when the slot is free or draining;
  // otherwise it is dropped and flagged as an overrun.
  always_comb begin
    load        = result_valid && (!out_valid_q || out_ready);
    out_data_d  = load ? result : out_data_q;
    overrun_d   = result_valid && out_valid_q && !out_ready;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (cnt_q != '0);

`ifdef SENSOR_SAMPLER_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Count overrun pulses, saturating at all-ones; the count moves on the same
  // edge the pulse appears.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  // Overrun counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_sampler
// Description : Self-checking bench for sensor_sampler against a queue-based
//               reference model of the sampling/averaging/handshake rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_sampler;

  localparam int DATA_W      = 8;
  localparam int DIV         = 4;
  localparam int LOG2_AVG    = 2;
  localparam int SYNC_STAGES = 2;
  localparam int NAVG        = 1 << LOG2_AVG;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [DATA_W-1:0] sensor_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic              busy;
`ifdef SENSOR_SAMPLER_OVERRUN_CNT_EN
  logic [15:0]       overrun_cnt;
`endif

  sensor_sampler #(
    .DATA_W     (DATA_W),
    .DIV        (DIV),
    .LOG2_AVG   (LOG2_AVG),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sensor_in  (sensor_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
`ifdef SENSOR_SAMPLER_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_hist[$];     // raw bus values still travelling through the synchroniser
  int m_samples[$];  // samples collected in the current averaging window
  int m_div;
  int m_out_data;
  bit m_valid;
  bit m_ovr;
  int m_ovr_cnt;

  logic [10:0] dut_vec;
  assign dut_vec = {out_data, out_valid, overrun, busy};

  function automatic logic [10:0] exp_vec();
    return {8'(m_out_data), m_valid, m_ovr, (m_samples.size() != 0)};
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < SYNC_STAGES; k++) m_hist.push_back(0);
    m_samples.delete();
    m_div      = 0;
    m_out_data = 0;
    m_valid    = 0;
    m_ovr      = 0;
    m_ovr_cnt  = 0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then settle just after the edge.
  task automatic step();
    int synced;
    int sum;
    int result;
    bit rv;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      synced = m_hist.pop_front();
      m_hist.push_back(int'(sensor_in));
      rv     = 0;
      result = 0;
      m_ovr  = 0;
      if (!en) begin
        m_div = 0;
        m_samples.delete();
      end else if (m_div == DIV - 1) begin
        m_div = 0;
        m_samples.push_back(synced);
        if (m_samples.size() == NAVG) begin
          sum = 0;
          foreach (m_samples[k]) sum += m_samples[k];
          result = sum / NAVG;
          rv     = 1;
          m_samples.delete();
        end
      end else begin
        m_div++;
      end
      if (rv) begin
        if (!m_valid || out_ready) begin
          m_out_data = result;
          m_valid    = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (m_ovr && m_ovr_cnt != 65535) m_ovr_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; out_ready = 1'b0; sensor_in = 8'hA5;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec !== 11'd0) $display("FAIL reset_async got %h want %h", dut_vec, 11'd0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      sensor_in = 8'($urandom);
      step();
      n_checks++;
      if (dut_vec !== 11'd0) $display("FAIL reset_hold cyc %0d got %h want %h", i, dut_vec, 11'd0);
      else n_pass++;
    end
    reset = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_release cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_constant();
    int first_valid = -1;
    int ovr_seen = 0;
    sensor_in = 8'h40; out_ready = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (out_valid && first_valid < 0) first_valid = i;
      if (overrun) ovr_seen++;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL constant cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (i % 16 == 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h40)
          $display("FAIL constant_word cyc %0d got v=%b d=%h want v=1 d=40", i, out_valid, out_data);
        else n_pass++;
      end
    end
    n_checks++;
    if (first_valid != 16) $display("FAIL constant_latency got %0d want 16", first_valid);
    else n_pass++;
    n_checks++;
    if (ovr_seen != 0) $display("FAIL constant_overrun got %0d want 0", ovr_seen);
    else n_pass++;
  endtask

  task automatic test_average();
    logic [7:0] vals [8];
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
    for (int k = 4; k < 8; k++) vals[k] = 8'hFF;
    en = 1'b0; out_ready = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      en = 1'b1;
      sensor_in = vals[i / 4];
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL average cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (i == 15 || i == 31) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== ((i == 15) ? 8'h02 : 8'hFF))
          $display("FAIL average_word cyc %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data,
                   (i == 15) ? 8'h02 : 8'hFF);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overrun();
    int ovr_seen = 0;
    en = 1'b0; out_ready = 1'b1;
    step();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sensor_in = 8'($urandom);
      step();
      if (overrun) ovr_seen++;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL overrun cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (ovr_seen != 1 || out_valid !== 1'b1)
      $display("FAIL overrun_pulses got %0d v=%b want 1 v=1", ovr_seen, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL overrun_drain got v=%b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL overrun_drain_model got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    en = 1'b0; out_ready = 1'b1; sensor_in = 8'h10;
    step();
    en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      out_ready = (i <= 16 || i == 32);
      sensor_in = (i <= 16) ? 8'h10 : 8'h30;
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL b2b cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h30 || overrun !== 1'b0)
      $display("FAIL b2b_load got v=%b d=%h o=%b want v=1 d=30 o=0", out_valid, out_data, overrun);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sensor_in = 8'($urandom);
      step();
    end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL areset_busy_before got %b want 1", busy);
    else n_pass++;
    #3 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec !== 11'd0) $display("FAIL areset_immediate got %h want %h", dut_vec, 11'd0);
    else n_pass++;
    sensor_in = 8'h22;
    step();
    step();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL areset_after cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22)
      $display("FAIL areset_word got v=%b d=%h want v=1 d=22", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_en_toggle();
    en = 1'b0; out_ready = 1'b1;
    step();
    en = 1'b1; out_ready = 1'b0; sensor_in = 8'h11;
    for (int i = 1; i <= 24; i++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL entog_fill cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL entog_partial got b=%b v=%b want b=1 v=1", busy, out_valid);
    else n_pass++;
    en = 1'b0; sensor_in = 8'h55;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11)
      $display("FAIL entog_off got b=%b v=%b d=%h want b=0 v=1 d=11", busy, out_valid, out_data);
    else n_pass++;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL entog_on cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55)
      $display("FAIL entog_word got v=%b d=%h want v=1 d=55", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sensor_in = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      en        = ($urandom_range(0, 99) < 97);
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL random cyc %0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
`ifdef SENSOR_SAMPLER_OVERRUN_CNT_EN
      n_checks++;
      if (overrun_cnt !== 16'(m_ovr_cnt))
        $display("FAIL random_ovr_cnt cyc %0d got %0d want %0d", i, overrun_cnt, m_ovr_cnt);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_average();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_en_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
